mult_seq_unit: RTL and testbench
================================

Name: mult_seq_unit

Overview:
Iterative shift-add multiplier that produces the 64-bit multResult consumed by the downstream HI/LO / mul splitting stage. It supports MIPS mult (signed), multu (unsigned) and mul; mul uses the low word. The block takes operands on a start pulse, runs one partial-product step per clock, and presents a registered 64-bit product with a one-cycle done pulse.

Parameters:
WIDTH, 32, operand width in bits; the product is 2*WIDTH bits.

Ports:
Clk  input  1  system clock, rising-edge.
Rst  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled on a rising Clk edge.
isSigned  input  1  1 = two's-complement operands (mult/mul), 0 = unsigned (multu); sampled with start.
opA  input  WIDTH  multiplicand; sampled with start.
opB  input  WIDTH  multiplier; sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; multResult is valid in the same cycle.
multResult  output  2*WIDTH  registered product; feeds the HI/LO split stage.

Behaviour:
- Reset (async, Rst=1): state=IDLE; busy=0, done=0, multResult=0; counter, accumulator and operand registers all 0.
- States:
  - IDLE: busy=0, done=0. If start=1 at edge E0, go to RUN.
  - RUN: busy=1, done=0. Lasts exactly WIDTH cycles.
  - DONE: busy=0, done=1, held for one cycle.
- Capture at E0:
  - magA=|opA| and magB=|opB| when isSigned=1 (bitwise as given when isSigned=0).
  - negRes = isSigned & (opA[MSB] ^ opB[MSB]).
  - acc=0; counter=WIDTH.
  - Magnitude of the most negative value (0x8000_0000) is 0x8000_0000 read as unsigned; no special case is needed.
- Each RUN edge:
  - If multiplier LSB=1, add magA (zero-extended) into the upper half of a (2*WIDTH+1)-bit accumulator.
  - Shift the accumulator right by 1 and shift the multiplier right by 1.
  - Decrement the counter.
- On the RUN edge where the counter goes 1->0:
  - multResult <= negRes ? two's-complement(final acc) : final acc.
  - Go to DONE.
- Latency: start sampled at E0 -> done=1 in the cycle after edge E_WIDTH (WIDTH clocks after E0). Issue interval is WIDTH+1 cycles back-to-back.
- multResult holds its value from DONE until the next completed operation. It does not change during RUN.
- start while busy=1 is ignored; operands are not re-sampled.
- start during the DONE cycle is accepted: that edge moves to RUN, done drops, and the new operands are captured.
- Rst asserted mid-RUN aborts immediately: multResult=0, no done pulse. Operation resumes with the first start after Rst deasserts.
- isSigned, opA and opB are don't-care except at the start sample edge.
- Zero operand: RUN still takes WIDTH cycles; there is no early termination.

Test Plan:
1. Reset: Rst=1 mid-idle, then release -> busy=0, done=0, multResult=64'h0; no done pulse until a start.
2. Unsigned: start, isSigned=0, opA=32'hFFFF_FFFF, opB=32'hFFFF_FFFF -> done exactly 32 clocks after the start edge, multResult=64'hFFFF_FFFE_0000_0001; busy high for 32 cycles.
3. Signed mixed: isSigned=1, opA=-7 (32'hFFFF_FFF9), opB=6 -> multResult=64'hFFFF_FFFF_FFFF_FFD6 (-42). Both negative, opA=opB=32'h8000_0000 -> 64'h4000_0000_0000_0000.
4. Start during busy: start at E0 with 3*5; a second start at E10 with 100*100 -> single done at E32 with multResult=64'd15; the second request is ignored.
5. Back-to-back: start asserted in the DONE cycle with 2*3 after a 4*4 -> first done shows 16, next done 32 cycles later shows 6; multResult stays 16 throughout the second RUN.
6. Reset mid-op: start 9*9, assert Rst at cycle 12 of RUN -> busy=0, done=0, multResult=0 immediately (async). A subsequent start 9*9 gives 81 after a full 32 cycles.

Source files
------------

// File: rtl/mult_seq_unit.sv
// mult_seq_unit: iterative shift-add multiplier for MIPS mult/multu/mul.
// One partial-product step per clock over WIDTH cycles. The multiply runs on
// operand magnitudes and the sign is applied once at the end. The 2*WIDTH-bit
// product is registered and qualified by a one-cycle done pulse.
//
// Handshake: start is a single-cycle request sampled on a rising Clk edge.
// It is accepted when busy=0, which covers both IDLE and the DONE cycle.
// While busy=1, start is ignored and the operands are not sampled. done is
// high for exactly one cycle, and multResult is valid in that cycle. The
// product then holds until the next operation completes.
module mult_seq_unit #(
   parameter int WIDTH = 32
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               start,
   input  logic               isSigned,
   input  logic [WIDTH-1:0]   opA,
   input  logic [WIDTH-1:0]   opB,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] multResult
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic               load;
   logic               step;
   logic               last;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mult_b;
   logic               neg_res;
   logic [2*WIDTH:0]   acc;
   logic [2*WIDTH:0]   acc_step;
   logic [WIDTH:0]     upper_sum;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;

   // Operand magnitudes at capture. 0x8000_0000 maps onto itself, and that
   // value is the correct magnitude when it is read as unsigned.
   always_comb begin
      abs_a = opA;
      abs_b = opB;
      if (isSigned && opA[WIDTH-1]) abs_a = (~opA) + WIDTH'(1);
      if (isSigned && opB[WIDTH-1]) abs_b = (~opB) + WIDTH'(1);
   end

   // One shift-add step: conditionally add into the upper half, then shift right.
   always_comb begin
      upper_sum   = acc[2*WIDTH:WIDTH] + (mult_b[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
      acc_step    = {1'b0, upper_sum, acc[WIDTH-1:1]};
      prod        = acc_step[2*WIDTH-1:0];
      prod_signed = neg_res ? ((~prod) + (2*WIDTH)'(1)) : prod;
   end

   // State register.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic and status outputs.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      load       = 1'b0;
      step       = 1'b0;
      last       = (cnt == CNT_ONE);
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: capture operands, iterate, and register the signed-corrected product.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         cnt        <= '0;
         mag_a      <= '0;
         mult_b     <= '0;
         neg_res    <= 1'b0;
         acc        <= '0;
         multResult <= '0;
      end else if (load) begin
         cnt     <= CNT_INIT;
         mag_a   <= abs_a;
         mult_b  <= abs_b;
         neg_res <= isSigned & (opA[WIDTH-1] ^ opB[WIDTH-1]);
         acc     <= '0;
      end else if (step) begin
         cnt    <= cnt - CNT_ONE;
         acc    <= acc_step;
         mult_b <= mult_b >> 1;
         if (last) multResult <= prod_signed;
      end
   end

endmodule

// File: tb/tb_mult_seq_unit.sv
// tb_mult_seq_unit: directed and randomized checks of mult_seq_unit against an
// arithmetic reference that uses plain 64-bit signed or unsigned multiplication.
module tb_mult_seq_unit;

   logic        Clk;
   logic        Rst;
   logic        start;
   logic        isSigned;
   logic [31:0] opA;
   logic [31:0] opB;
   logic        busy;
   logic        done;
   logic [63:0] multResult;

   logic [63:0] exp_q[$];
   logic [63:0] last_res;
   int          n_checks;
   int          n_pass;

   mult_seq_unit #(.WIDTH(32)) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .start      (start),
      .isSigned   (isSigned),
      .opA        (opA),
      .opB        (opB),
      .busy       (busy),
      .done       (done),
      .multResult (multResult)
   );

   // Clock and watchdog.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // Reference model: the full-width product computed directly.
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
      longint      sa;
      longint      sb;
      logic [63:0] ua;
      logic [63:0] ub;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      ua = {32'h0, a};
      ub = {32'h0, b};
      return ua * ub;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 4))
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Called just after the start edge. Follows the run to done and scores it.
   // inject_at > 0 raises a second start (100*100) before edge E<inject_at>.
   task automatic wait_done(input string tag, input int inject_at);
      int          n;
      int          busy_n;
      int          hold_bad;
      logic [63:0] e;
      n = 0;
      busy_n = 0;
      hold_bad = 0;
      while (!done && n < 40) begin
         if (busy) busy_n++;
         if (multResult !== last_res) hold_bad++;
         if (n == inject_at - 1) begin
            start = 1'b1;
            opA = 32'd100;
            opB = 32'd100;
            isSigned = 1'b0;
         end else begin
            start = 1'b0;
            opA = $urandom;
            opB = $urandom;
            isSigned = 1'($urandom_range(0, 1));
         end
         tick();
         n++;
      end
      start = 1'b0;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      check({tag, "_latency"}, 64'(n), 64'd32);
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'd32);
      check({tag, "_hold"}, 64'(hold_bad), 64'd0);
      check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
      check({tag, "_result"}, multResult, e);
      last_res = e;
   endtask

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input string tag, input int inject_at);
      start = 1'b1;
      opA = a;
      opB = b;
      isSigned = s;
      exp_q.push_back(model(a, b, s));
      tick();
      start = 1'b0;
      wait_done(tag, inject_at);
   endtask

   initial begin
      int dcount;
      n_checks = 0;
      n_pass = 0;
      last_res = 64'd0;
      Rst = 1'b1;
      start = 1'b0;
      isSigned = 1'b0;
      opA = 32'd0;
      opB = 32'd0;

      // Reset behaviour.
      tick();
      tick();
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_result", multResult, 64'd0);
      Rst = 1'b0;
      dcount = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done || busy) dcount++;
      end
      check("idle_no_activity", 64'(dcount), 64'd0);
      check("idle_result", multResult, 64'd0);

      // Directed products.
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max", 0);
      check("multu_max_value", multResult, 64'hFFFF_FFFE_0000_0001);
      tick();
      check("done_one_cycle", {63'd0, done}, 64'd0);
      do_op(32'hFFFF_FFF9, 32'd6, 1'b1, "mult_neg7x6", 0);
      check("mult_neg7x6_value", multResult, 64'hFFFF_FFFF_FFFF_FFD6);
      tick();
      do_op(32'h8000_0000, 32'h8000_0000, 1'b1, "mult_minxmin", 0);
      check("mult_minxmin_value", multResult, 64'h4000_0000_0000_0000);
      tick();
      do_op(32'd0, 32'h1234_5678, 1'b1, "zero_op", 0);
      tick();

      // A start while busy is ignored.
      do_op(32'd3, 32'd5, 1'b0, "busy_start", 10);
      check("busy_start_value", multResult, 64'd15);
      dcount = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done || busy) dcount++;
      end
      check("busy_start_no_second_op", 64'(dcount), 64'd0);
      check("busy_start_result_held", multResult, 64'd15);

      // Back-to-back: the next start arrives in the DONE cycle.
      do_op(32'd4, 32'd4, 1'b0, "b2b_first", 0);
      check("b2b_first_value", multResult, 64'd16);
      do_op(32'd2, 32'd3, 1'b0, "b2b_second", 0);
      check("b2b_second_value", multResult, 64'd6);
      tick();

      // Reset asserted in the middle of a run.
      start = 1'b1;
      opA = 32'd9;
      opB = 32'd9;
      isSigned = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      check("pre_abort_busy", {63'd0, busy}, 64'd1);
      #2 Rst = 1'b1;
      #1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_result", multResult, 64'd0);
      tick();
      Rst = 1'b0;
      last_res = 64'd0;
      dcount = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done || busy) dcount++;
      end
      check("abort_no_done", 64'(dcount), 64'd0);
      do_op(32'd9, 32'd9, 1'b0, "after_abort", 0);
      check("after_abort_value", multResult, 64'd81);
      tick();

      // Randomized operations, with or without idle gaps between them.
      for (int i = 0; i < 24; i++) begin
         do_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), "rand", 0);
         if ($urandom_range(0, 1) == 1) begin
            tick();
            check("rand_done_drop", {63'd0, done}, 64'd0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
